fetch_prefetch_unit: RTL and testbench

- Parametrised successor of the fixed PC/PC+4 fetch stage. Holds the PC, issues handshaked requests to a variable-latency instruction memory and buffers returned words in a DEPTH-entry prefetch queue.
- Decode consumes {pc, instruction} through a valid/ready interface. A decode stall is ready=0.
- A redirect (branch/jump from the later stages) flushes the queue and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/prefetch_fifo.sv | 48 ++++
 rtl/fetch_prefetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the fetch prefetch unit.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int PC_INC     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular prefetch queue; the head entry is read straight from storage.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});

  // Storage, pointers and occupancy; a flush realigns the read side onto the write side.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {WIDTH{1'b0}};
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// PC/fetch FSM feeding a prefetch queue; FETCH_PREFETCH_PERF_EN adds perf counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  input  logic              out_ready
`ifdef FETCH_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_empty_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic [ADDR_W-1:0]  fpc;
  logic [ADDR_W-1:0]  fpc_next;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CW-1:0]      count;
  logic [CW-1:0]      cnt_after_ack;
  logic               full;
  logic               empty;
  logic [ADDR_W+DATA_W-1:0] head;

  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;
  assign {out_pc, out_inst} = head;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({fpc, imem_data}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Next-state, next-PC and queue control.
  always_comb begin
    state_next    = state;
    fpc_next      = fpc;
    push          = 1'b0;
    flush         = 1'b0;
    cnt_after_ack = count + CW'(1) - CW'(pop);
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fpc_next   = redirect_pc;
          flush      = 1'b1;
          state_next = WAIT;
        end else if (!full || pop) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response arriving with the redirect is stale but closes the request.
          fpc_next   = redirect_pc;
          flush      = 1'b1;
          state_next = imem_ack ? WAIT : DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          fpc_next   = fpc + ADDR_W'(PC_INC);
          state_next = (cnt_after_ack < FULL_CNT) ? WAIT : IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          fpc_next   = redirect_pc;
          flush      = 1'b1;
          state_next = imem_ack ? WAIT : DROP;
        end else if (imem_ack) begin
          state_next = WAIT;
        end else begin
          state_next = DROP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, fetch PC and the registered memory request; DROP freezes the stale address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      fpc       <= fpc_next;
      imem_req  <= (state_next != IDLE);
      imem_addr <= (state_next == DROP) ? imem_addr : fpc_next;
    end
  end

`ifdef FETCH_PREFETCH_PERF_EN
  logic [CW-1:0] flush_lost;
  logic          ack_drop;

  // Entries thrown away by a flush (the head popped that cycle is not lost) and dropped acks.
  always_comb begin
    flush_lost = {CW{1'b0}};
    ack_drop   = 1'b0;
    if (redirect_valid) flush_lost = count - CW'(pop);
    else                flush_lost = {CW{1'b0}};
    if (imem_ack && (state == DROP || (state == WAIT && redirect_valid))) ack_drop = 1'b1;
    else                                                                 ack_drop = 1'b0;
  end

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_empty_cnt <= 32'd0;
    end else begin
      perf_stall_cnt <= sat_add32(perf_stall_cnt, {31'd0, out_valid & ~out_ready});
      perf_flush_cnt <= sat_add32(perf_flush_cnt, 32'(flush_lost) + 32'(ack_drop));
      perf_empty_cnt <= sat_add32(perf_empty_cnt, {31'd0, ~out_valid});
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench with a transaction-level queue model checked every cycle.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_data;
  logic        w_redir = 1'b0;
  logic [31:0] w_rpc = 32'd0;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  fetch_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );

  fetch_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(w_data),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .out_valid(w_valid), .out_pc(w_pc), .out_inst(w_inst), .out_ready(w_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Memory responder: ack in the lat-th cycle a request has been held.
  int lat = 1;
  int age = 0;
  initial begin
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      if (imem_req === 1'b1) begin
        age++;
        if (age >= lat) begin
          imem_ack  = 1'b1;
          imem_data = mem_word(imem_addr);
          age       = 0;
        end else begin
          imem_ack = 1'b0;
        end
      end else begin
        imem_ack = 1'b0;
        age      = 0;
      end
    end
  end

  // Zero-wait responder for the wrap instance.
  initial begin
    w_ack  = 1'b0;
    w_data = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      w_ack  = (w_req === 1'b1);
      w_data = mem_word(w_addr);
    end
  end

  // Capture first fetches/outputs of the wrap instance.
  logic [31:0] w_addrs[$];
  logic [63:0] w_outs[$];
  initial forever begin
    @(negedge clock);
    if (reset === 1'b0) begin
      if (w_req && w_ack && w_addrs.size() < 3) w_addrs.push_back(w_addr);
      if (w_valid && w_outs.size() < 3) w_outs.push_back({w_pc, w_inst});
    end
  end

  // Reference model: expected queue contents, fetch PC and stale-request tracking.
  logic [63:0] mq[$];
  logic [31:0] m_fpc = 32'h0;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_addr = 32'h0;
  bit          chk_on = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] pop_log[$];

  initial forever begin
    @(negedge clock);
    if (chk_on) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("out_pc", {32'd0, out_pc}, {32'd0, mq[0][63:32]});
        chk("out_inst", {32'd0, out_inst}, {32'd0, mq[0][31:0]});
      end
      if (imem_req) chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_stale ? m_stale_addr : m_fpc});
      if (mq.size() == DEPTH) chk("req_when_full", {63'd0, imem_req}, 64'd0);
      if (prev_hold) begin
        chk("req_held", {63'd0, imem_req}, 64'd1);
        chk("addr_held", {32'd0, imem_addr}, {32'd0, prev_addr});
      end
    end
    prev_hold = (reset === 1'b0) && (imem_req === 1'b1) && (imem_ack === 1'b0);
    prev_addr = imem_addr;
    if (reset !== 1'b0) begin
      mq.delete();
      m_fpc   = 32'h0;
      m_stale = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        pop_log.push_back(out_pc);
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (redirect_valid) begin
        mq.delete();
        if (imem_req && !imem_ack && !m_stale) begin
          m_stale      = 1'b1;
          m_stale_addr = m_fpc;
        end else if (imem_req && imem_ack) begin
          m_stale = 1'b0;
        end
        m_fpc = redirect_pc;
      end else if (imem_req && imem_ack) begin
        if (m_stale) m_stale = 1'b0;
        else begin
          mq.push_back({m_fpc, imem_data});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  task automatic do_reset(input int l);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    step();
    lat = l;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    step();
    chk_on = 1'b1;
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_inst", {32'd0, out_inst}, 64'd0);
    step();
    reset = 1'b0;

    // back-to-back fetch, zero-wait memory
    step();
    chk("t1_req", {63'd0, imem_req}, 64'd1);
    chk("t1_addr0", {32'd0, imem_addr}, 64'h0);
    step();
    chk("t1_addr4", {32'd0, imem_addr}, 64'h4);
    chk("t1_pc0", {32'd0, out_pc}, 64'h0);
    chk("t1_inst0", {32'd0, out_inst}, 64'hDEAD_0000);
    step();
    chk("t1_addr8", {32'd0, imem_addr}, 64'h8);
    chk("t1_pc4", {32'd0, out_pc}, 64'h4);
    chk("t1_inst4", {32'd0, out_inst}, 64'hDEAD_0004);
    step();
    chk("t1_addr12", {32'd0, imem_addr}, 64'hC);
    chk("t1_pc8", {32'd0, out_pc}, 64'h8);
    chk("t1_inst8", {32'd0, out_inst}, 64'hDEAD_0008);

    // stall fills the queue, then resume
    out_ready = 1'b0;
    do_reset(1);
    for (int i = 0; i < 5; i++) step();
    chk("t2_idle_req", {63'd0, imem_req}, 64'd0);
    chk("t2_full_pc", {32'd0, out_pc}, 64'h0);
    for (int i = 0; i < 3; i++) step();
    chk("t2_still_idle", {63'd0, imem_req}, 64'd0);
    chk("t2_stall_pc", {32'd0, out_pc}, 64'h0);
    out_ready = 1'b1;
    step();
    chk("t2_resume_req", {63'd0, imem_req}, 64'd1);
    chk("t2_resume_addr", {32'd0, imem_addr}, 64'h10);
    chk("t2_next_pc", {32'd0, out_pc}, 64'h4);

    // redirect while a slow request is outstanding
    out_ready = 1'b1;
    do_reset(3);
    n = 0;
    while (!(imem_req && !imem_ack && imem_addr == 32'h8) && n < 40) begin step(); n++; end
    chk("t3_wait8", {63'd0, imem_req && !imem_ack && imem_addr == 32'h8}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("t3_drop_req", {63'd0, imem_req}, 64'd1);
    chk("t3_drop_addr", {32'd0, imem_addr}, 64'h8);
    chk("t3_flushed", {63'd0, out_valid}, 64'd0);
    step();
    chk("t3_drop_addr2", {32'd0, imem_addr}, 64'h8);
    n = 0;
    while (!(imem_req && imem_addr == 32'h100) && n < 10) begin step(); n++; end
    chk("t3_new_addr", {63'd0, imem_req && imem_addr == 32'h100}, 64'd1);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("t3_first_pc", {32'd0, out_pc}, 64'h100);
    chk("t3_first_inst", {32'd0, out_inst}, 64'hDEAD_0100);

    // redirect coincident with an ack
    do_reset(1);
    n = 0;
    while (!(imem_ack && imem_addr == 32'h10) && n < 20) begin step(); n++; end
    chk("t4_ack10", {63'd0, imem_ack && imem_addr == 32'h10}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("t4_req", {63'd0, imem_req}, 64'd1);
    chk("t4_addr", {32'd0, imem_addr}, 64'h40);
    chk("t4_empty", {63'd0, out_valid}, 64'd0);
    step();
    chk("t4_pc", {32'd0, out_pc}, 64'h40);
    chk("t4_inst", {32'd0, out_inst}, 64'hDEAD_0040);

    // full queue with overlapping pop/ack across pointer wrap
    out_ready = 1'b0;
    do_reset(1);
    pop_log.delete();
    for (int i = 0; i < 8; i++) step();
    chk("t5_full_idle", {63'd0, imem_req}, 64'd0);
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3 != 2);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t5_pop_count", {63'd0, pop_log.size() >= 12}, 64'd1);
    for (int k = 0; k < pop_log.size(); k++)
      chk("t5_order", {32'd0, pop_log[k]}, 64'(4 * k));

    // reset in the middle of DROP
    do_reset(4);
    n = 0;
    while (!(imem_req && !imem_ack && imem_addr == 32'h4) && n < 20) begin step(); n++; end
    chk("t6_wait4", {63'd0, imem_req && !imem_ack && imem_addr == 32'h4}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("t6_drop_addr", {32'd0, imem_addr}, 64'h4);
    reset = 1'b1;
    step();
    chk("t6_rst_req", {63'd0, imem_req}, 64'd0);
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("t6_restart_addr", {32'd0, imem_addr}, 64'h0);
    chk("t6_restart_valid", {63'd0, out_valid}, 64'd0);
    step();
    step();

    // PC wrap on the instance reset to 0xFFFFFFFC
    chk("w_fetches", {63'd0, w_addrs.size() == 3}, 64'd1);
    chk("w_outputs", {63'd0, w_outs.size() == 3}, 64'd1);
    if (w_addrs.size() == 3 && w_outs.size() == 3) begin
      chk("w_addr0", {32'd0, w_addrs[0]}, 64'hFFFF_FFFC);
      chk("w_addr1", {32'd0, w_addrs[1]}, 64'h0);
      chk("w_addr2", {32'd0, w_addrs[2]}, 64'h4);
      chk("w_out0", w_outs[0], 64'hFFFF_FFFC_2152_FFFC);
      chk("w_out1", w_outs[1], 64'h0000_0000_DEAD_0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
